fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation core.
- Replaces the direct PC-to-ROM combinational path with a sequential fetcher: PC generation, ready/valid request to an instruction memory with variable in-order latency, an instruction prefetch FIFO, and redirect/flush on jump or taken branch.
- Sits between instruction memory and the instruction decoder.
- Redirect requests come from the register-file/branch logic.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited requests to a variable-latency
// in-order instruction memory, a first-word-fall-through prefetch FIFO and redirect/flush.
module fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic               o_imem_req,
  input  logic               i_imem_ready,
  input  logic               i_imem_valid,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic [ADDR_W-1:0]  o_pc
);

  localparam int                PW      = $clog2(FIFO_DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CW:0]       DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0]  resp_pc_reg, resp_pc_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [CW-1:0]      outstanding_reg, outstanding_next;
  logic [CW-1:0]      drop_reg, drop_next;
  logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;

  logic [INSTR_W-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [FIFO_DEPTH];

  logic credit_ok;
  logic accept;
  logic push;
  logic pop;
  logic resp_drop;
  logic resp_seen;

  // Every slot either holds data or is reserved by an in-flight request, so the FIFO cannot overflow.
  assign credit_ok  = ({1'b0, count_reg} + {1'b0, outstanding_reg}) < DEPTH_W;
  assign o_imem_req = !i_rst && !i_redirect && credit_ok;
  assign accept     = o_imem_req && i_imem_ready;

  assign resp_drop  = i_imem_valid && (drop_reg != '0);
  assign push       = i_imem_valid && (drop_reg == '0) && (outstanding_reg != '0) && !i_redirect;
  assign resp_seen  = i_imem_valid && ((drop_reg != '0) || (outstanding_reg != '0));

  assign o_valid     = (count_reg != '0);
  assign pop         = o_valid && i_ready;
  assign o_instr     = o_valid ? instr_mem[rd_ptr_reg] : '0;
  assign o_instr_pc  = o_valid ? pc_mem[rd_ptr_reg] : '0;
  assign o_imem_addr = fetch_pc_reg;
  assign o_pc        = fetch_pc_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (i_redirect) begin
      // Everything still in flight becomes stale; a response landing now is one of them.
      fetch_pc_next    = i_redirect_pc;
      resp_pc_next     = i_redirect_pc;
      count_next       = '0;
      rd_ptr_next      = '0;
      wr_ptr_next      = '0;
      outstanding_next = '0;
      drop_next        = drop_reg + outstanding_reg - CW'(resp_seen);
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + STEP;
      end
      if (resp_drop) begin
        drop_next = drop_reg - 1'b1;
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + STEP;
        wr_ptr_next  = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      outstanding_next = outstanding_reg + CW'(accept) - CW'(push);
      count_next       = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // Storage needs no reset: count gates visibility and outputs are masked while empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= i_imem_data;
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order memory with programmable latency,
// per-scenario tasks with hand-computed expectations.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ready;
  logic        i_imem_valid;
  logic [15:0] i_imem_data;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        i_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic [15:0] o_pc;

  logic        w_rst;
  logic [15:0] w_addr;
  logic        w_req;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [15:0] w_instr_pc;
  logic [15:0] w_pc;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  fetch_unit u_dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_addr(o_imem_addr), .o_imem_req(o_imem_req), .i_imem_ready(i_imem_ready),
    .i_imem_valid(i_imem_valid), .i_imem_data(i_imem_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_pc(o_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(1)) u_wrap (
    .i_clk(i_clk), .i_rst(w_rst),
    .o_imem_addr(w_addr), .o_imem_req(w_req), .i_imem_ready(1'b1),
    .i_imem_valid(1'b0), .i_imem_data(16'h0000),
    .o_valid(w_valid), .o_instr(w_instr), .o_instr_pc(w_instr_pc), .i_ready(1'b0),
    .i_redirect(1'b0), .i_redirect_pc(16'h0000), .o_pc(w_pc)
  );

  // Memory model: accepts sampled mid-cycle, responses presented in order after lat cycles.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [15:0] acc_log[$];
  req_t        new_req;
  int          lat = 1;
  int          cyc = 0;

  always @(negedge i_clk) begin
    if (o_imem_req && i_imem_ready) begin
      new_req.addr = o_imem_addr;
      new_req.due  = cyc + lat;
      pend.push_back(new_req);
      acc_log.push_back(o_imem_addr);
    end
  end

  always @(posedge i_clk) begin
    #1;
    cyc = cyc + 1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      i_imem_valid = 1'b1;
      i_imem_data  = pend[0].addr ^ 16'hA5A5;
      void'(pend.pop_front());
    end else begin
      i_imem_valid = 1'b0;
      i_imem_data  = 16'h0000;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  // Leaves the DUT in its first post-reset cycle with memory idle and both readies low.
  task automatic do_reset(input int l);
    i_imem_ready  = 1'b0;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_rst         = 1'b1;
    lat           = l;
    for (int k = 0; k < 20 && pend.size() != 0; k++) tick();
    tick();
    tick();
    acc_log.delete();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    sample();
    total += 6;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", o_imem_req); end
    if (o_imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", o_imem_addr); end
    if (o_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", o_pc); end
    if (o_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", o_instr); end
    if (o_instr_pc !== 16'h0000) begin bad++; $display("FAIL reset_instr_pc got=%h want=0000", o_instr_pc); end
    $display("test_reset: checked reset outputs");
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    do_reset(1);
    i_imem_ready = 1'b1;
    i_ready      = 1'b1;
    exp_pc       = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      sample();
      total += 2;
      if (o_imem_req !== 1'b1) begin bad++; $display("FAIL stream_req cycle=%0d got=%b want=1", c, o_imem_req); end
      if (o_valid !== (c >= 3)) begin bad++; $display("FAIL stream_valid cycle=%0d got=%b want=%b", c, o_valid, c >= 3); end
      if (c >= 3) begin
        total += 2;
        if (o_instr_pc !== exp_pc) begin bad++; $display("FAIL stream_pc cycle=%0d got=%h want=%h", c, o_instr_pc, exp_pc); end
        if (o_instr !== (exp_pc ^ 16'hA5A5)) begin bad++; $display("FAIL stream_instr cycle=%0d got=%h want=%h", c, o_instr, exp_pc ^ 16'hA5A5); end
        exp_pc = exp_pc + 16'd1;
      end
      tick();
    end
    $display("test_stream: latency 1 stream through pc %h", exp_pc);
  endtask

  task automatic test_backpressure();
    do_reset(2);
    i_imem_ready = 1'b1;
    i_ready      = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sample();
      tick();
    end
    sample();
    total += 4;
    if (acc_log.size() !== 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", acc_log.size()); end
    for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
      total++;
      if (acc_log[k] !== 16'(k)) begin bad++; $display("FAIL bp_addr idx=%0d got=%h want=%h", k, acc_log[k], 16'(k)); end
    end
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full got=%b want=0", o_imem_req); end
    if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", o_valid); end
    if (o_instr_pc !== 16'h0000) begin bad++; $display("FAIL bp_head got=%h want=0000", o_instr_pc); end
    tick();
    i_ready = 1'b1;
    sample();
    total += 2;
    if (o_instr_pc !== 16'h0000) begin bad++; $display("FAIL bp_pop_head got=%h want=0000", o_instr_pc); end
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_pop got=%b want=0", o_imem_req); end
    tick();
    i_ready = 1'b0;
    sample();
    total += 3;
    if (o_instr_pc !== 16'h0001) begin bad++; $display("FAIL bp_next_head got=%h want=0001", o_instr_pc); end
    if (o_imem_req !== 1'b1) begin bad++; $display("FAIL bp_req_credit got=%b want=1", o_imem_req); end
    if (o_imem_addr !== 16'h0004) begin bad++; $display("FAIL bp_req_addr got=%h want=0004", o_imem_addr); end
    tick();
    sample();
    total += 2;
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_again got=%b want=0", o_imem_req); end
    if (acc_log.size() !== 5) begin bad++; $display("FAIL bp_accepts_after got=%0d want=5", acc_log.size()); end
    $display("test_backpressure: %0d requests accepted", acc_log.size());
  endtask

  task automatic test_redirect();
    int  first_cyc;
    do_reset(3);
    i_imem_ready = 1'b1;
    i_ready      = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      sample();
      tick();
    end
    i_redirect    = 1'b1;
    i_redirect_pc = 16'h0040;
    sample();
    total++;
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b want=0", o_imem_req); end
    tick();
    i_redirect = 1'b0;
    sample();
    total += 4;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", o_valid); end
    if (o_imem_addr !== 16'h0040) begin bad++; $display("FAIL redir_addr got=%h want=0040", o_imem_addr); end
    if (o_pc !== 16'h0040) begin bad++; $display("FAIL redir_pc got=%h want=0040", o_pc); end
    if (o_imem_req !== 1'b1) begin bad++; $display("FAIL redir_req_after got=%b want=1", o_imem_req); end
    first_cyc = 0;
    for (int c = 6; c <= 25 && first_cyc == 0; c++) begin
      tick();
      sample();
      if (o_valid) first_cyc = c;
    end
    total += 3;
    if (first_cyc !== 9) begin bad++; $display("FAIL redir_first_cycle got=%0d want=9", first_cyc); end
    if (o_instr_pc !== 16'h0040) begin bad++; $display("FAIL redir_first_pc got=%h want=0040", o_instr_pc); end
    if (o_instr !== (16'h0040 ^ 16'hA5A5)) begin bad++; $display("FAIL redir_first_instr got=%h want=%h", o_instr, 16'h0040 ^ 16'hA5A5); end
    $display("test_redirect: first valid at cycle %0d pc %h", first_cyc, o_instr_pc);
  endtask

  task automatic test_double_redirect();
    int first_cyc;
    do_reset(2);
    i_imem_ready = 1'b1;
    i_ready      = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      sample();
      tick();
    end
    i_redirect    = 1'b1;
    i_redirect_pc = 16'h0040;
    sample();
    total++;
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL dredir_req1 got=%b want=0", o_imem_req); end
    tick();
    i_redirect_pc = 16'h0080;
    sample();
    total += 2;
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL dredir_req2 got=%b want=0", o_imem_req); end
    if (o_valid !== 1'b0) begin bad++; $display("FAIL dredir_valid2 got=%b want=0", o_valid); end
    tick();
    i_redirect = 1'b0;
    first_cyc  = 0;
    for (int c = 5; c <= 25 && first_cyc == 0; c++) begin
      sample();
      if (o_valid) first_cyc = c;
      else tick();
    end
    total += 3;
    if (first_cyc !== 8) begin bad++; $display("FAIL dredir_first_cycle got=%0d want=8", first_cyc); end
    if (o_instr_pc !== 16'h0080) begin bad++; $display("FAIL dredir_first_pc got=%h want=0080", o_instr_pc); end
    if (o_instr !== (16'h0080 ^ 16'hA5A5)) begin bad++; $display("FAIL dredir_first_instr got=%h want=%h", o_instr, 16'h0080 ^ 16'hA5A5); end
    tick();
    sample();
    total++;
    if (o_instr_pc !== 16'h0081) begin bad++; $display("FAIL dredir_second_pc got=%h want=0081", o_instr_pc); end
    $display("test_double_redirect: first valid at cycle %0d", first_cyc);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE;
    exp_addr[1] = 16'hFFFF;
    exp_addr[2] = 16'h0000;
    exp_addr[3] = 16'h0001;
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      total += 2;
      if (w_req !== 1'b1) begin bad++; $display("FAIL wrap_req idx=%0d got=%b want=1", k, w_req); end
      if (w_addr !== exp_addr[k]) begin bad++; $display("FAIL wrap_addr idx=%0d got=%h want=%h", k, w_addr, exp_addr[k]); end
      tick();
    end
    sample();
    total += 2;
    if (w_req !== 1'b0) begin bad++; $display("FAIL wrap_req_full got=%b want=0", w_req); end
    if (w_pc !== 16'h0002) begin bad++; $display("FAIL wrap_pc got=%h want=0002", w_pc); end
    $display("test_wrap: fetch pc now %h", w_pc);
  endtask

  task automatic test_async_reset();
    int first_cyc;
    do_reset(3);
    i_ready      = 1'b0;
    i_imem_ready = 1'b1;
    sample();
    tick();
    i_imem_ready = 1'b0;
    tick();
    tick();
    i_imem_ready = 1'b1;
    tick();
    tick();
    // cycle 6: one entry buffered, addresses 1 and 2 still in flight
    total += 3;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", o_valid); end
    if (o_imem_req !== 1'b1) begin bad++; $display("FAIL arst_pre_req got=%b want=1", o_imem_req); end
    if (o_pc !== 16'h0003) begin bad++; $display("FAIL arst_pre_pc got=%h want=0003", o_pc); end
    #1;
    i_rst        = 1'b1;
    i_imem_ready = 1'b0;
    #1;
    total += 4;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", o_valid); end
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b want=0", o_imem_req); end
    if (o_pc !== 16'h0000) begin bad++; $display("FAIL arst_pc got=%h want=0000", o_pc); end
    if (o_instr !== 16'h0000) begin bad++; $display("FAIL arst_instr got=%h want=0000", o_instr); end
    i_rst = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      tick();
      sample();
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL arst_late_resp cycle=%0d got=%b want=0", c, o_valid); end
    end
    tick();
    i_imem_ready = 1'b1;
    sample();
    total++;
    if (o_imem_addr !== 16'h0000) begin bad++; $display("FAIL arst_restart_addr got=%h want=0000", o_imem_addr); end
    first_cyc = 0;
    for (int c = 12; c <= 30 && first_cyc == 0; c++) begin
      tick();
      sample();
      if (o_valid) first_cyc = c;
    end
    total += 3;
    if (first_cyc !== 15) begin bad++; $display("FAIL arst_first_cycle got=%0d want=15", first_cyc); end
    if (o_instr_pc !== 16'h0000) begin bad++; $display("FAIL arst_first_pc got=%h want=0000", o_instr_pc); end
    if (o_instr !== 16'hA5A5) begin bad++; $display("FAIL arst_first_instr got=%h want=A5A5", o_instr); end
    $display("test_async_reset: restart valid at cycle %0d", first_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst         = 1'b1;
    w_rst         = 1'b1;
    i_imem_ready  = 1'b0;
    i_imem_valid  = 1'b0;
    i_imem_data   = 16'h0000;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
